// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - PC redirect sequencer for the 5-stage OTTER pipeline
//
// Purpose:
//   Picks the jal/jalr/branch target for a resolving EX-stage control
//   transfer and steers fetch onto it. When fetch is enabled this happens
//   with zero latency. When fetch is stalled, the target is parked in a
//   hold register until fetch is enabled again. Misaligned targets are
//   reported and not redirected. The block also keeps saturating counts of
//   redirects and misaligned events.
//
// Ports:
//   CLK, RST_N              clock, synchronous active-low reset
//   EX_VALID                EX stage holds a valid, non-squashed instruction
//   EX_IS_JAL/JALR/BR       EX instruction type flags
//   EX_BR_TAKEN             branch condition result
//   JAL, BRANCH, JALR       candidate targets from the address generator
//   PC_EN                   fetch PC register loads this cycle
//   PC_SEL, REDIRECT_ADDR   PC mux select and redirect target
//   FLUSH_IF_ID/ID_EX       pipeline register squashes
//   HOLD_BUSY               redirect pending in the hold register
//   MISALIGN_ERR, ERR_ADDR  misaligned-target pulse and last bad target
//   REDIRECT_CNT            saturating count of accepted redirects
//   MISALIGN_CNT            saturating count of misaligned events
module branch_redirect_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EX_VALID,
  input  logic             EX_IS_JAL,
  input  logic             EX_IS_JALR,
  input  logic             EX_IS_BR,
  input  logic             EX_BR_TAKEN,
  input  logic [XLEN-1:0]  JAL,
  input  logic [XLEN-1:0]  BRANCH,
  input  logic [XLEN-1:0]  JALR,
  input  logic             PC_EN,
  output logic             PC_SEL,
  output logic [XLEN-1:0]  REDIRECT_ADDR,
  output logic             FLUSH_IF_ID,
  output logic             FLUSH_ID_EX,
  output logic             HOLD_BUSY,
  output logic             MISALIGN_ERR,
  output logic [XLEN-1:0]  ERR_ADDR,
  output logic [CNT_W-1:0] REDIRECT_CNT,
  output logic [CNT_W-1:0] MISALIGN_CNT
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [XLEN-1:0]  JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t          state;
  logic [XLEN-1:0] hold_addr;

  logic            r_evt;
  logic [XLEN-1:0] tgt;
  logic            mis;
  logic            red_req;  // aligned resolve while idle
  logic            mis_evt;  // misaligned resolve while idle
  logic            fire;     // redirect accepted by fetch this cycle

  // Target selection. jalr clears bit 0 of its target; jalr wins over
  // jal, which wins over branch, even when several flags are set.
  always_comb begin
    r_evt   = EX_VALID & (EX_IS_JAL | EX_IS_JALR | (EX_IS_BR & EX_BR_TAKEN));
    tgt     = EX_IS_JALR ? (JALR & JALR_MASK) :
              EX_IS_JAL  ? JAL : BRANCH;
    // Without compressed instructions, target bit 1 must be clear.
    mis     = tgt[1];
    red_req = (state == IDLE) & r_evt & ~mis;
    mis_evt = (state == IDLE) & r_evt & mis;
  end

  // While RST_N is low, every combinational output is forced to zero.
  always_comb begin
    PC_SEL        = 1'b0;
    REDIRECT_ADDR = '0;
    HOLD_BUSY     = 1'b0;
    MISALIGN_ERR  = 1'b0;
    fire          = 1'b0;
    if (RST_N) begin
      if (state == HOLD) begin
        PC_SEL        = 1'b1;
        REDIRECT_ADDR = hold_addr;
        HOLD_BUSY     = 1'b1;
        fire          = PC_EN;
      end else if (red_req) begin
        PC_SEL        = 1'b1;
        REDIRECT_ADDR = tgt;
        fire          = PC_EN;
      end else begin
        MISALIGN_ERR  = mis_evt;
      end
    end
    FLUSH_IF_ID = fire;
    FLUSH_ID_EX = fire;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state        <= IDLE;
      hold_addr    <= '0;
      ERR_ADDR     <= '0;
      REDIRECT_CNT <= '0;
      MISALIGN_CNT <= '0;
    end else begin
      if (fire && REDIRECT_CNT != '1)
        REDIRECT_CNT <= REDIRECT_CNT + CNT_ONE;
      if (mis_evt) begin
        ERR_ADDR <= tgt;
        if (MISALIGN_CNT != '1)
          MISALIGN_CNT <= MISALIGN_CNT + CNT_ONE;
      end
      case (state)
        IDLE: begin
          // Fetch is stalled, so park the target until fetch can accept it.
          if (red_req && !PC_EN) begin
            hold_addr <= tgt;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (PC_EN)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - scoreboard bench for branch_redirect_ctrl
module tb_branch_redirect_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ex_valid, ex_is_jal, ex_is_jalr, ex_is_br, ex_br_taken;
  logic [31:0] jal, branch, jalr;
  logic        pc_en;

  logic        pc_sel, fif, fie, busy, merr;
  logic [31:0] raddr, eaddr;
  logic [15:0] rcnt, mcnt;

  logic        pc_sel2, fif2, fie2, busy2, merr2;
  logic [31:0] raddr2, eaddr2;
  logic [1:0]  rcnt2, mcnt2;

  branch_redirect_ctrl #(.XLEN(32), .CNT_W(16)) dut (
    .CLK(clk), .RST_N(rst_n), .EX_VALID(ex_valid), .EX_IS_JAL(ex_is_jal),
    .EX_IS_JALR(ex_is_jalr), .EX_IS_BR(ex_is_br), .EX_BR_TAKEN(ex_br_taken),
    .JAL(jal), .BRANCH(branch), .JALR(jalr), .PC_EN(pc_en),
    .PC_SEL(pc_sel), .REDIRECT_ADDR(raddr), .FLUSH_IF_ID(fif), .FLUSH_ID_EX(fie),
    .HOLD_BUSY(busy), .MISALIGN_ERR(merr), .ERR_ADDR(eaddr),
    .REDIRECT_CNT(rcnt), .MISALIGN_CNT(mcnt)
  );

  // Narrow-counter instance on the same stimulus, for saturation.
  branch_redirect_ctrl #(.XLEN(32), .CNT_W(2)) dut2 (
    .CLK(clk), .RST_N(rst_n), .EX_VALID(ex_valid), .EX_IS_JAL(ex_is_jal),
    .EX_IS_JALR(ex_is_jalr), .EX_IS_BR(ex_is_br), .EX_BR_TAKEN(ex_br_taken),
    .JAL(jal), .BRANCH(branch), .JALR(jalr), .PC_EN(pc_en),
    .PC_SEL(pc_sel2), .REDIRECT_ADDR(raddr2), .FLUSH_IF_ID(fif2), .FLUSH_ID_EX(fie2),
    .HOLD_BUSY(busy2), .MISALIGN_ERR(merr2), .ERR_ADDR(eaddr2),
    .REDIRECT_CNT(rcnt2), .MISALIGN_CNT(mcnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        pc_sel;
    logic [31:0] addr;
    logic        flush;
    logic        busy;
    logic        merr;
    logic [31:0] err_addr;
    logic [15:0] rcnt;
    logic [15:0] mcnt;
    logic [1:0]  rcnt2;
    logic [1:0]  mcnt2;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference state: a pending-redirect flag, its address, the last bad
  // target and unbounded event counts. Saturation is applied when reading.
  bit          m_pend;
  logic [31:0] m_pend_addr;
  logic [31:0] m_err;
  int          m_nred, m_nmis;

  bit          n_pend;
  logic [31:0] n_pend_addr;
  logic [31:0] n_err;
  int          n_nred, n_nmis;

  function automatic logic [15:0] sat16(int n);
    return (n > 65535) ? 16'hFFFF : 16'(n);
  endfunction

  function automatic logic [1:0] sat2(int n);
    return (n > 3) ? 2'd3 : 2'(n);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs, push the expected outputs for that cycle,
  // and advance the reference across the clock edge.
  task automatic step(input bit rst, input bit v, input bit fj, input bit fjr,
                      input bit fb, input bit tk, input logic [31:0] a_jal,
                      input logic [31:0] a_br, input logic [31:0] a_jalr,
                      input bit en);
    exp_t        e;
    bit          resolve;
    logic [31:0] target;
    rst_n = rst; ex_valid = v; ex_is_jal = fj; ex_is_jalr = fjr; ex_is_br = fb;
    ex_br_taken = tk; jal = a_jal; branch = a_br; jalr = a_jalr; pc_en = en;

    resolve = v && (fj || fjr || (fb && tk));
    if (fjr)     target = {a_jalr[31:1], 1'b0};
    else if (fj) target = a_jal;
    else         target = a_br;

    e          = '0;
    e.err_addr = m_err;
    e.rcnt     = sat16(m_nred);
    e.mcnt     = sat16(m_nmis);
    e.rcnt2    = sat2(m_nred);
    e.mcnt2    = sat2(m_nmis);
    n_pend = m_pend; n_pend_addr = m_pend_addr; n_err = m_err;
    n_nred = m_nred; n_nmis = m_nmis;

    if (!rst) begin
      n_pend = 0; n_pend_addr = 0; n_err = 0; n_nred = 0; n_nmis = 0;
    end else if (m_pend) begin
      e.pc_sel = 1; e.addr = m_pend_addr; e.busy = 1; e.flush = en;
      if (en) begin n_pend = 0; n_nred++; end
    end else if (resolve && target[1]) begin
      e.merr = 1; n_err = target; n_nmis++;
    end else if (resolve) begin
      e.pc_sel = 1; e.addr = target; e.flush = en;
      if (en) n_nred++;
      else begin n_pend = 1; n_pend_addr = target; end
    end
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    m_pend = n_pend; m_pend_addr = n_pend_addr; m_err = n_err;
    m_nred = n_nred; m_nmis = n_nmis;
  endtask

  // Monitor: compares DUT outputs mid-cycle against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_sel",       32'(pc_sel), 32'(e.pc_sel));
        chk("redirect_addr", raddr,      e.addr);
        chk("flush_if_id",  32'(fif),    32'(e.flush));
        chk("flush_id_ex",  32'(fie),    32'(e.flush));
        chk("hold_busy",    32'(busy),   32'(e.busy));
        chk("misalign_err", 32'(merr),   32'(e.merr));
        chk("err_addr",     eaddr,       e.err_addr);
        chk("redirect_cnt", 32'(rcnt),   32'(e.rcnt));
        chk("misalign_cnt", 32'(mcnt),   32'(e.mcnt));
        chk("redirect_cnt_w2", 32'(rcnt2), 32'(e.rcnt2));
        chk("misalign_cnt_w2", 32'(mcnt2), 32'(e.mcnt2));
      end
    end
  end

  initial begin
    int wait_cycles;
    rst_n = 0; ex_valid = 0; ex_is_jal = 0; ex_is_jalr = 0; ex_is_br = 0;
    ex_br_taken = 0; jal = 0; branch = 0; jalr = 0; pc_en = 0;
    m_pend = 0; m_pend_addr = 0; m_err = 0; m_nred = 0; m_nmis = 0;
    @(posedge clk);
    #1;

    // Reset, then idle.
    step(0, 1, 1, 0, 0, 0, 32'h80, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Taken branch with fetch enabled, then not-taken.
    step(1, 1, 0, 0, 1, 1, 0, 32'h140, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 1, 0, 0, 32'h140, 0, 1);
    // jalr under a stall; a jal arriving during HOLD must be ignored.
    step(1, 1, 0, 1, 0, 0, 0, 0, 32'h2005, 0);
    step(1, 1, 1, 0, 0, 0, 32'h300, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 32'h302, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 32'h300, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Misaligned jal.
    step(1, 1, 1, 0, 0, 0, 32'h102, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Reset while in HOLD.
    step(1, 1, 1, 0, 0, 0, 32'h80, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Back-to-back taken branches: narrow counter saturates at 3.
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 1, 1, 0, 32'h40 + 32'(i * 4), 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Misaligned events saturate the narrow misalign counter.
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 1, 1, 0, 32'h1002 + 32'(i * 4), 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t0, t1, t2;
      t0 = {$urandom(), 2'b00} | 32'($urandom_range(0, 3));
      t1 = {$urandom(), 2'b00} | 32'($urandom_range(0, 3));
      t2 = $urandom();
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 1) == 0), ($urandom_range(0, 1) == 0),
           t0, t1, t2, ($urandom_range(0, 2) != 0));
    end
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequences PC redirection for the 5-stage OTTER pipeline.
- Takes the jal/branch/jalr targets from the branch address generator, the EX-stage branch decision and instruction type, and the fetch-stage PC enable.
- Drives the PC mux select, the redirect address and the IF/ID and ID/EX flushes.
- Holds a redirect across fetch stalls, traps misaligned targets, and keeps saturating redirect statistics.

Parameters:
- XLEN, 32, address/target width.
- CNT_W, 16, width of each statistics counter.

Ports:
- CLK  in  1  system clock, all state updates on the rising edge.
- RST_N  in  1  synchronous active-low reset.
- EX_VALID  in  1  EX stage holds a valid, non-squashed instruction.
- EX_IS_JAL  in  1  EX instruction is jal.
- EX_IS_JALR  in  1  EX instruction is jalr.
- EX_IS_BR  in  1  EX instruction is a conditional branch.
- EX_BR_TAKEN  in  1  branch condition true (meaningful only with EX_IS_BR).
- JAL  in  XLEN  jal target (PC + J-imm).
- BRANCH  in  XLEN  branch target (PC + B-imm).
- JALR  in  XLEN  jalr target (RS1 + I-imm), unmasked.
- PC_EN  in  1  fetch PC register will load this cycle.
- PC_SEL  out  1  0 = PC+4, 1 = REDIRECT_ADDR.
- REDIRECT_ADDR  out  XLEN  redirect target.
- FLUSH_IF_ID  out  1  squash the IF/ID register this cycle.
- FLUSH_ID_EX  out  1  squash the ID/EX register this cycle.
- HOLD_BUSY  out  1  a redirect is pending in the hold register.
- MISALIGN_ERR  out  1  one-cycle pulse on a misaligned target.
- ERR_ADDR  out  XLEN  last misaligned target, registered.
- REDIRECT_CNT  out  CNT_W  accepted redirects, saturating.
- MISALIGN_CNT  out  CNT_W  misaligned events, saturating.

Behaviour:
- Resolve event R = EX_VALID & (EX_IS_JAL | EX_IS_JALR | (EX_IS_BR & EX_BR_TAKEN)).
- Target priority: JALR, then JAL, then BRANCH. The JALR target is {JALR[XLEN-1:1],1'b0}. More than one type flag set is illegal, but the priority still applies.
- Misaligned means selected target bit[1] = 1 (no compressed support).
- Misaligned event:
  - MISALIGN_ERR pulses combinationally that cycle.
  - ERR_ADDR captures the target at the next edge.
  - MISALIGN_CNT increments at the next edge.
  - No redirect, no flush, no state change. Trap handling is downstream.
- FSM has two states: IDLE and HOLD.
- IDLE, aligned R, PC_EN = 1:
  - Zero-latency redirect: PC_SEL = 1, REDIRECT_ADDR = target, FLUSH_IF_ID = FLUSH_ID_EX = 1, all combinationally the same cycle.
  - REDIRECT_CNT increments at the edge. State stays IDLE.
- IDLE, aligned R, PC_EN = 0:
  - Target latched into the hold register at the edge; go to HOLD.
  - PC_SEL = 1 and REDIRECT_ADDR = target are still driven combinationally that cycle.
  - Flushes stay low.
- HOLD:
  - PC_SEL = 1, REDIRECT_ADDR = hold register, HOLD_BUSY = 1.
  - All EX inputs are ignored, including R and misalign checks.
  - When PC_EN = 1: FLUSH_IF_ID = FLUSH_ID_EX = 1 that cycle, REDIRECT_CNT increments, return to IDLE at the edge.
  - While PC_EN = 0: outputs stay stable, flushes stay low.
- In IDLE with no aligned R: PC_SEL = 0, REDIRECT_ADDR = 0, flushes 0, HOLD_BUSY = 0.
- Counters saturate at all-ones and never wrap.
- Reset (RST_N = 0 at an edge), including mid-HOLD:
  - State to IDLE; hold register, ERR_ADDR and both counters to 0.
  - The pending redirect is dropped.
- While RST_N = 0, all combinational outputs are forced low/zero regardless of inputs: PC_SEL, REDIRECT_ADDR, flushes, HOLD_BUSY, MISALIGN_ERR.
- A redirect and a misalign can never occur together (mutually exclusive by construction).

Test Plan:
- Reset, then RST_N = 1 with EX_VALID = 0 for 3 cycles -> PC_SEL = 0, flushes 0, REDIRECT_CNT = 0, ERR_ADDR = 0.
- EX_IS_BR = 1, EX_BR_TAKEN = 1, BRANCH = 0x0000_0140, PC_EN = 1 -> same cycle PC_SEL = 1, REDIRECT_ADDR = 0x140, both flushes 1; next cycle REDIRECT_CNT = 1. Repeat with EX_BR_TAKEN = 0 -> no redirect, counter unchanged.
- EX_IS_JALR = 1, JALR = 0x0000_2005, PC_EN = 0 for 3 cycles, then PC_EN = 1:
  - REDIRECT_ADDR = 0x2004 throughout.
  - HOLD_BUSY = 1 for 3 cycles; flushes only on the PC_EN = 1 cycle.
  - A new JAL = 0x300 presented during HOLD is ignored.
- EX_IS_JAL = 1, JAL = 0x0000_0102, PC_EN = 1 -> MISALIGN_ERR pulse, PC_SEL = 0, no flush; next cycle ERR_ADDR = 0x102, MISALIGN_CNT = 1.
- Enter HOLD with JAL = 0x80, assert RST_N = 0 for one edge while PC_EN = 0 -> IDLE, HOLD_BUSY = 0, PC_SEL = 0 after release, REDIRECT_CNT = 0.
- CNT_W = 2, 5 back-to-back taken branches with PC_EN = 1 -> REDIRECT_CNT sequence 1, 2, 3, 3, 3.
